// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one n-bit adder/subtractor between two requesters.
// Requests use valid/ready; each result is held with its requester ID until the consumer takes it.

module subtractor_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cntrl,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         overflow
);

  logic [N-1:0] y_eff;
  logic [N:0]   sum;

  // Subtraction is x + ~y + 1; cntrl doubles as the carry-in.
  assign y_eff    = y ^ {N{cntrl}};
  assign sum      = {1'b0, x} + {1'b0, y_eff} + {{N{1'b0}}, cntrl};
  assign s        = sum[N-1:0];
  assign c_out    = sum[N];
  assign overflow = (x[N-1] == y_eff[N-1]) && (s[N-1] != x[N-1]);

endmodule

module addsub_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  input  logic         req1_sub,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_s,
  output logic         resp_c_out,
  output logic         resp_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  logic         ptr;
  logic [N-1:0] op_x;
  logic [N-1:0] op_y;
  logic         op_sub;
  logic         op_id;
  logic         grant;
  logic         accept;
  logic [N-1:0] alu_s;
  logic         alu_c_out;
  logic         alu_overflow;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ptr;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  subtractor_nbit #(.N(N)) u_addsub (
    .x        (op_x),
    .y        (op_y),
    .cntrl    (op_sub),
    .s        (alu_s),
    .c_out    (alu_c_out),
    .overflow (alu_overflow)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values; all registers are cleared by the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      op_x          <= '0;
      op_y          <= '0;
      op_sub        <= 1'b0;
      op_id         <= 1'b0;
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_s        <= '0;
      resp_c_out    <= 1'b0;
      resp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_x   <= grant ? req1_x   : req0_x;
            op_y   <= grant ? req1_y   : req0_y;
            op_sub <= grant ? req1_sub : req0_sub;
            op_id  <= grant;
            state  <= EXEC;
          end
        end
        EXEC: begin
          resp_s        <= alu_s;
          resp_c_out    <= alu_c_out;
          resp_overflow <= alu_overflow;
          resp_id       <= op_id;
          resp_valid    <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            ptr        <= ~resp_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
